dram_scheduler: RTL and testbench
=================================

DRAM_SCHEDULER -- requirements
Module: dram_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default ADDRESS_LEN: row address width.
REQ-003 SHALL have parameter BEAT_W, default BURST_ACCESS_WIDTH: burst beat width.
REQ-004 SHALL have parameter BEATS, default BURST_LEN: beats per row access.
REQ-005 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles.
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, reset, synchronous, active-high.
REQ-007 SHALL have requester ports: req_valid in NUM_REQ; req_write in NUM_REQ; req_addr in NUM_REQ x ADDR_W; req_wdata in NUM_REQ x BEAT_W*BEATS (beat 0 = LSBs); req_ready out NUM_REQ, one-hot accept pulse.
REQ-008 SHALL have response ports: resp_valid out NUM_REQ, one-hot done pulse; resp_rdata out BEAT_W*BEATS, shared read data; resp_err out 1, timeout flag qualified by resp_valid.
REQ-009 SHALL have memory ports: mem_addr out ADDR_W; mem_read_en out 1; mem_write_en out 1; mem_wdata out BEAT_W; mem_ready in 1; mem_complete in 1; mem_rdata in BEAT_W; mem_valid in 1.

Function
REQ-010 SHALL use FSM states IDLE, ISSUE, XFER, RESP, WAIT_RDY.
REQ-011 In IDLE with mem_ready=1 and any req_valid, SHALL grant one requester round-robin starting at last_grant+1 (mod NUM_REQ), pulse its req_ready for 1 cycle, latch addr/write/wdata, and go to ISSUE.
REQ-012 SHALL NOT grant while mem_ready=0; requests SHALL stay pending without loss.
REQ-013 ISSUE: SHALL drive mem_addr and assert exactly one of mem_read_en or mem_write_en, then go to XFER next cycle.
REQ-014 The enable SHALL stay high continuously from ISSUE until the cycle mem_complete is sampled high, then deassert on the next edge.
REQ-015 Write: mem_wdata SHALL equal latched beat[wbeat]; wbeat starts at 0 and increments on each cycle mem_valid=1; it saturates at BEATS-1.
REQ-016 Read: on each mem_valid=1 cycle, mem_rdata SHALL be stored to beat[rbeat] and rbeat incremented; beats beyond BEATS SHALL be discarded; unfilled beats SHALL read 0.
REQ-017 On mem_complete in XFER, SHALL go to RESP; RESP SHALL pulse resp_valid[grant] for exactly 1 cycle with resp_rdata stable, then go to WAIT_RDY.
REQ-018 resp_rdata SHALL hold its value until the next read completes; for writes resp_rdata SHALL remain unchanged.
REQ-019 WAIT_RDY SHALL return to IDLE when mem_ready=1; last_grant SHALL update at RESP.
REQ-020 A watchdog SHALL count cycles spent in XFER; reaching TIMEOUT SHALL drop enables, set resp_err=1, and go to RESP.
REQ-021 resp_err SHALL be 0 in RESP for normal completion.
REQ-022 A requester dropping req_valid after grant SHALL NOT abort the transaction.
REQ-023 At most one memory transaction SHALL be outstanding.

Reset
REQ-024 On rst, state SHALL be IDLE; req_ready, resp_valid, resp_err, mem_read_en, and mem_write_en SHALL be 0; resp_rdata, mem_addr, and mem_wdata SHALL be 0; last_grant SHALL be NUM_REQ-1.
REQ-025 rst during a transaction SHALL abandon it with no resp_valid pulse; enables SHALL be 0 from the next edge.

Structure
REQ-026 The scheduler state enum and the default ADDRESS_LEN, BURST_ACCESS_WIDTH, and BURST_LEN values SHALL live in package types.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req vector, last_grant; outputs: one-hot grant, index).

Verification (BEAT_W=8, BEATS=4, NUM_REQ=4)
REQ-028 Single write: req 2 writes addr 5 with data 0x44332211 -> mem_wdata 0x11,0x22,0x33,0x44 on valid beats; resp_valid=0b0100 once; resp_err=0.
REQ-029 Read: memory returns beats 0xAA,0xBB,0xCC,0xDD -> resp_rdata=0xDDCCBBAA; resp_valid pulses for requester 0 for 1 cycle.
REQ-030 Fairness: all 4 req_valid held high -> grant order 0,1,2,3,0 after reset.
REQ-031 Watchdog: mem_complete never asserts -> enables drop after 1024 XFER cycles; resp_valid plus resp_err=1.
REQ-032 Back-pressure and reset: mem_ready=0 -> no req_ready; rst asserted in XFER -> enables 0 next cycle and no resp_valid.

Source files
------------

// File: rtl/types.sv
// Shared types and default geometry for the DRAM request scheduler.
package types;

    localparam int ADDRESS_LEN        = 16;
    localparam int BURST_ACCESS_WIDTH = 8;
    localparam int BURST_LEN          = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        XFER     = 3'd2,
        RESP     = 3'd3,
        WAIT_RDY = 3'd4
    } sched_state_t;

endpackage

// File: rtl/dram_scheduler_if.sv
// Requester, response and memory-side signal bundle of the DRAM scheduler.
// The master modport is the scheduler's view; slave is the environment's.
interface dram_scheduler_if
    import types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDRESS_LEN,
    parameter int BEAT_W  = BURST_ACCESS_WIDTH,
    parameter int BEATS   = BURST_LEN
) ();

    // requester side
    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ-1:0]                    req_write;
    logic [NUM_REQ-1:0][ADDR_W-1:0]        req_addr;
    logic [NUM_REQ-1:0][BEAT_W*BEATS-1:0]  req_wdata;
    logic [NUM_REQ-1:0]                    req_ready;

    // response side
    logic [NUM_REQ-1:0]                    resp_valid;
    logic [BEAT_W*BEATS-1:0]               resp_rdata;
    logic                                  resp_err;

    // memory side
    logic [ADDR_W-1:0]                     mem_addr;
    logic                                  mem_read_en;
    logic                                  mem_write_en;
    logic [BEAT_W-1:0]                     mem_wdata;
    logic                                  mem_ready;
    logic                                  mem_complete;
    logic [BEAT_W-1:0]                     mem_rdata;
    logic                                  mem_valid;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_read_en, mem_write_en, mem_wdata,
        input  mem_ready, mem_complete, mem_rdata, mem_valid
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_read_en, mem_write_en, mem_wdata,
        output mem_ready, mem_complete, mem_rdata, mem_valid
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the most recently served requester has lowest priority.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // requester index sitting 'off+1' places after base, modulo NUM_REQ
    function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = (int'(base) + 1 + off) % NUM_REQ;
        return s[IDX_W-1:0];
    endfunction

    // requests rotated so that position 0 is the highest-priority requester
    logic [NUM_REQ-1:0] rot;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign rot[gi] = req[wrap(last_grant, gi)];
    end

    // first set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        logic found;
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found     = 1'b1;
                grant_idx = wrap(last_grant, k);
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dram_scheduler.sv
// Multi-requester DRAM access scheduler: grants one requester at a time in
// round-robin order, runs a single burst read or write against the memory
// port, and returns a one-cycle completion pulse to the granted requester.
module dram_scheduler
    import types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = ADDRESS_LEN,
    parameter int BEAT_W  = BURST_ACCESS_WIDTH,
    parameter int BEATS   = BURST_LEN,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    dram_scheduler_if.master    bus
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int DATA_W  = BEAT_W * BEATS;
    localparam int BEAT_CW = $clog2(BEATS + 1);
    localparam int WDOG_W  = $clog2(TIMEOUT + 1);

    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    localparam logic [BEAT_CW-1:0] BEAT_END  = BEAT_CW'(BEATS);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);

    // control state
    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
    logic                  write_q, write_d;
    // write data for writes, collected beats for reads
    logic [DATA_W-1:0]     buf_q, buf_d;
    // write: beat being presented (saturating); read: beats captured so far
    logic [BEAT_CW-1:0]    beat_q, beat_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;

    // registered outputs
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic [BEAT_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]      arb_idx;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    function automatic logic [BEAT_W-1:0] get_beat(input logic [DATA_W-1:0] d,
                                                   input logic [BEAT_CW-1:0] i);
        return d[int'(i)*BEAT_W +: BEAT_W];
    endfunction

    // next-state and next-output logic for the whole transaction sequence
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_idx_d  = grant_idx_q;
        write_d      = write_q;
        buf_d        = buf_q;
        beat_d       = beat_q;
        wdog_d       = wdog_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_addr_d   = mem_addr_q;
        rd_en_d      = rd_en_q;
        wr_en_d      = wr_en_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                // hold requests while memory is busy; they stay pending upstream
                if (bus.mem_ready && (|bus.req_valid)) begin
                    grant_idx_d = arb_idx;
                    req_ready_d = arb_grant;
                    write_d     = bus.req_write[arb_idx];
                    mem_addr_d  = bus.req_addr[arb_idx];
                    beat_d      = '0;
                    wdog_d      = '0;
                    if (bus.req_write[arb_idx]) begin
                        buf_d       = bus.req_wdata[arb_idx];
                        mem_wdata_d = bus.req_wdata[arb_idx][BEAT_W-1:0];
                    end else begin
                        // unfilled read beats must come back as zero
                        buf_d = '0;
                    end
                    rd_en_d = !bus.req_write[arb_idx];
                    wr_en_d = bus.req_write[arb_idx];
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                state_d = XFER;
            end

            XFER: begin
                if (bus.mem_valid) begin
                    if (write_q) begin
                        if (beat_q < LAST_BEAT) begin
                            beat_d = beat_q + 1'b1;
                        end
                        mem_wdata_d = get_beat(buf_q, beat_d);
                    end else if (beat_q < BEAT_END) begin
                        buf_d[int'(beat_q)*BEAT_W +: BEAT_W] = bus.mem_rdata;
                        beat_d = beat_q + 1'b1;
                    end
                end

                if (bus.mem_complete) begin
                    rd_en_d                   = 1'b0;
                    wr_en_d                   = 1'b0;
                    resp_valid_d[grant_idx_q] = 1'b1;
                    if (!write_q) begin
                        // include a beat arriving in the same cycle as completion
                        resp_rdata_d = buf_d;
                    end
                    state_d = RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    // memory never finished: abandon and report an error
                    rd_en_d                   = 1'b0;
                    wr_en_d                   = 1'b0;
                    resp_valid_d[grant_idx_q] = 1'b1;
                    resp_err_d                = 1'b1;
                    state_d                   = RESP;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            RESP: begin
                last_grant_d = grant_idx_q;
                state_d      = WAIT_RDY;
            end

            WAIT_RDY: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_IDX;
            grant_idx_q  <= '0;
            write_q      <= 1'b0;
            buf_q        <= '0;
            beat_q       <= '0;
            wdog_q       <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_addr_q   <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            write_q      <= write_d;
            buf_q        <= buf_d;
            beat_q       <= beat_d;
            wdog_q       <= wdog_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_addr_q   <= mem_addr_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_read_en  = rd_en_q;
    assign bus.mem_write_en = wr_en_q;
    assign bus.mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_dram_scheduler.sv
// Directed bench for dram_scheduler (NUM_REQ=4, BEAT_W=8, BEATS=4) with a
// transaction-level reference model and a per-cycle compare process.
module tb_dram_scheduler;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dram_scheduler_if #(.NUM_REQ(NR), .ADDR_W(16), .BEAT_W(8), .BEATS(4)) bus ();

    dram_scheduler #(
        .NUM_REQ (NR),
        .ADDR_W  (16),
        .BEAT_W  (8),
        .BEATS   (4),
        .TIMEOUT (1024)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // expected completions, pushed by the stimulus, popped by the compare process
    typedef struct {
        int          idx;
        bit          err;
        logic [31:0] rdata;
    } resp_t;
    resp_t exp_q[$];

    logic [31:0] model_rd = '0;   // data of the most recent completed read
    logic [7:0]  beats_q [0:7];   // beats the memory will return
    logic [7:0]  obs_wd  [0:7];   // write beats observed on valid cycles

    // ---------------- reference model / compare process ----------------
    int          model_last = NR - 1;
    logic [3:0]  rv_prev    = '0;
    logic        mr_prev    = 1'b0;
    logic [3:0]  wr_prev    = '0;
    logic [3:0][15:0] addr_prev;
    logic [3:0][31:0] wd_prev;
    bit          cur_write;
    logic [15:0] cur_addr;
    logic [31:0] cur_data;
    int          wcnt      = 0;
    int          en_cycles = 0;
    int          exp_g;
    int          bi;
    resp_t       e;

    function automatic int rr_pick(input logic [3:0] pend, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (pend[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            model_last = NR - 1;
            wcnt       = 0;
        end else begin
            if (bus.mem_read_en && bus.mem_write_en)
                chk("both_enables", 2'b11, 2'b01);

            if (bus.req_ready != 0) begin
                exp_g = rr_pick(rv_prev, model_last);
                chk("grant_onehot", bus.req_ready, (exp_g < 0) ? 4'b0 : (4'b1 << exp_g));
                chk("grant_mem_ready", mr_prev, 1'b1);
                if (exp_g >= 0) begin
                    cur_write = wr_prev[exp_g];
                    cur_addr  = addr_prev[exp_g];
                    cur_data  = wd_prev[exp_g];
                end
                wcnt      = 0;
                en_cycles = 0;
            end

            if (bus.mem_read_en || bus.mem_write_en) begin
                en_cycles++;
                if (en_cycles == 1) begin
                    chk("mem_addr", bus.mem_addr, cur_addr);
                    chk("mem_write_en", bus.mem_write_en, cur_write);
                end
            end

            if (bus.mem_valid && bus.mem_write_en) begin
                bi = (wcnt < 3) ? wcnt : 3;
                chk("mem_wdata", bus.mem_wdata, cur_data[bi*8 +: 8]);
                if (wcnt < 8) obs_wd[wcnt] = bus.mem_wdata;
                wcnt++;
            end

            if (bus.resp_valid != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", bus.resp_valid, 4'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_valid", bus.resp_valid, 4'b1 << e.idx);
                    chk("resp_err", bus.resp_err, e.err);
                    chk("resp_rdata", bus.resp_rdata, e.rdata);
                    model_last = e.idx;
                end
            end
        end
        rv_prev   = bus.req_valid;
        mr_prev   = bus.mem_ready;
        wr_prev   = bus.req_write;
        addr_prev = bus.req_addr;
        wd_prev   = bus.req_wdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_grant(output int idx);
        int n;
        idx = -1;
        n   = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            if (bus.req_ready != 0) break;
            n++;
        end
        if (n >= 100) begin
            chk("grant_timeout", 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < NR; i++) if (bus.req_ready[i]) idx = i;
        end
    endtask

    // plays the memory: nbeats valid cycles, then optionally a completion
    task automatic serve(input int exp_idx, input int nbeats, input bit is_read, input bit complete_it);
        int          n;
        resp_t       r;
        logic [31:0] asm_rd;
        n = 0;
        while (!(bus.mem_read_en || bus.mem_write_en) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            chk("enable_timeout", 1'b1, 1'b0);
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i < nbeats; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = beats_q[i];
            @(posedge clk); #1;
        end
        bus.mem_valid = 1'b0;
        if (complete_it) begin
            asm_rd = '0;
            for (int i = 0; i < nbeats && i < 4; i++) asm_rd[i*8 +: 8] = beats_q[i];
            r.idx   = exp_idx;
            r.err   = 1'b0;
            r.rdata = is_read ? asm_rd : model_rd;
            exp_q.push_back(r);
            if (is_read) model_rd = asm_rd;
            bus.mem_complete = 1'b1;
            @(posedge clk); #1;
            bus.mem_complete = 1'b0;
        end
    endtask

    task automatic wait_resp(input int limit, output logic [3:0] v, output logic err, output logic [31:0] rd);
        int n;
        n = 0;
        v = '0; err = 1'b0; rd = '0;
        while (n < limit) begin
            @(negedge clk);
            if (bus.resp_valid != 0) begin
                v = bus.resp_valid; err = bus.resp_err; rd = bus.resp_rdata;
                break;
            end
            n++;
        end
        if (n >= limit) chk("resp_timeout", 1'b1, 1'b0);
    endtask

    task automatic set_req(input int i, input bit wr, input logic [15:0] a, input logic [31:0] d);
        bus.req_write[i] = wr;
        bus.req_addr[i]  = a;
        bus.req_wdata[i] = d;
        bus.req_valid[i] = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int          g;
    logic [3:0]  v;
    logic        er;
    logic [31:0] rd;
    int          order [0:4];

    initial begin
        bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_ready = 1'b1; bus.mem_complete = 1'b0; bus.mem_rdata = '0; bus.mem_valid = 1'b0;
        for (int i = 0; i < 8; i++) beats_q[i] = '0;

        // reset values
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 4'b0);
        chk("rst_resp_valid", bus.resp_valid, 4'b0);
        chk("rst_resp_err", bus.resp_err, 1'b0);
        chk("rst_enables", {bus.mem_read_en, bus.mem_write_en}, 2'b00);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 16'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 8'h0);

        // single write by requester 2; it drops req_valid right after the grant
        @(posedge clk); #1;
        set_req(2, 1'b1, 16'd5, 32'h44332211);
        wait_grant(g);
        bus.req_valid[2] = 1'b0;
        chk("write_grant_idx", g, 2);
        serve(2, 4, 1'b0, 1'b1);
        wait_resp(50, v, er, rd);
        chk("write_resp_valid", v, 4'b0100);
        chk("write_resp_err", er, 1'b0);
        chk("write_beat0", obs_wd[0], 8'h11);
        chk("write_beat1", obs_wd[1], 8'h22);
        chk("write_beat2", obs_wd[2], 8'h33);
        chk("write_beat3", obs_wd[3], 8'h44);

        // read by requester 0 returning AA BB CC DD
        @(posedge clk); #1;
        set_req(0, 1'b0, 16'h1234, 32'h0);
        beats_q[0] = 8'hAA; beats_q[1] = 8'hBB; beats_q[2] = 8'hCC; beats_q[3] = 8'hDD;
        wait_grant(g);
        bus.req_valid[0] = 1'b0;
        serve(0, 4, 1'b1, 1'b1);
        wait_resp(50, v, er, rd);
        chk("read_rdata", rd, 32'hDDCCBBAA);
        chk("read_resp_valid", v, 4'b0001);
        @(negedge clk);
        chk("read_pulse_one_cycle", bus.resp_valid, 4'b0);
        chk("rdata_held", bus.resp_rdata, 32'hDDCCBBAA);

        // short read: two beats, upper beats zero
        set_req(1, 1'b0, 16'h0042, 32'h0);
        beats_q[0] = 8'h01; beats_q[1] = 8'h02;
        wait_grant(g);
        bus.req_valid[1] = 1'b0;
        serve(1, 2, 1'b1, 1'b1);
        wait_resp(50, v, er, rd);
        chk("short_read_rdata", rd, 32'h00000201);

        // long read: six beats, only the first four kept
        @(posedge clk); #1;
        set_req(3, 1'b0, 16'h0077, 32'h0);
        for (int i = 0; i < 6; i++) beats_q[i] = 8'(8'h50 + i);
        wait_grant(g);
        bus.req_valid[3] = 1'b0;
        serve(3, 6, 1'b1, 1'b1);
        wait_resp(50, v, er, rd);
        chk("long_read_rdata", rd, 32'h53525150);

        // write with extra valid beats: last beat repeats
        @(posedge clk); #1;
        set_req(1, 1'b1, 16'h0100, 32'hDEADBEEF);
        wait_grant(g);
        bus.req_valid[1] = 1'b0;
        serve(1, 6, 1'b0, 1'b1);
        wait_resp(50, v, er, rd);
        chk("sat_beat5", obs_wd[5], 8'hDE);
        chk("write_keeps_rdata", rd, 32'h53525150);

        // back-pressure: no grant while mem_ready is low
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        set_req(3, 1'b1, 16'h0300, 32'hCAFEF00D);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_no_ready", bus.req_ready, 4'b0);
        end
        bus.mem_ready = 1'b1;
        wait_grant(g);
        bus.req_valid[3] = 1'b0;
        chk("bp_grant_idx", g, 3);
        serve(3, 4, 1'b0, 1'b1);
        wait_resp(50, v, er, rd);

        // watchdog: memory never completes
        @(posedge clk); #1;
        set_req(1, 1'b0, 16'h0BAD, 32'h0);
        wait_grant(g);
        bus.req_valid[1] = 1'b0;
        begin
            resp_t r;
            r.idx = 1; r.err = 1'b1; r.rdata = model_rd;
            exp_q.push_back(r);
        end
        serve(1, 0, 1'b1, 1'b0);
        wait_resp(1200, v, er, rd);
        chk("wdog_resp_valid", v, 4'b0010);
        chk("wdog_err", er, 1'b1);
        chk("wdog_enable_cycles", en_cycles, 1025);
        chk("wdog_enables_low", {bus.mem_read_en, bus.mem_write_en}, 2'b00);

        // reset in XFER abandons the transaction
        @(posedge clk); #1;
        set_req(2, 1'b0, 16'h0222, 32'h0);
        wait_grant(g);
        bus.req_valid[2] = 1'b0;
        @(posedge clk); #1;
        bus.mem_valid = 1'b1; bus.mem_rdata = 8'h99;
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_xfer_enables", {bus.mem_read_en, bus.mem_write_en}, 2'b00);
        rst = 1'b0;
        model_rd = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("rst_xfer_no_resp", bus.resp_valid, 4'b0);
        end

        // fairness after reset with all requesters held high
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 16'(16'h0400 + i), 32'h0);
        beats_q[0] = 8'h5A;
        for (int t = 0; t < 5; t++) begin
            wait_grant(g);
            order[t] = g;
            serve(t % NR, 1, 1'b1, 1'b1);
            wait_resp(50, v, er, rd);
        end
        bus.req_valid = '0;
        chk("fair_0", order[0], 0);
        chk("fair_1", order[1], 1);
        chk("fair_2", order[2], 2);
        chk("fair_3", order[3], 3);
        chk("fair_4", order[4], 0);

        repeat (5) @(posedge clk);
        chk("no_missing_resp", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
